sipo_read_gather: RTL and testbench
===================================

Name: sipo_read_gather

Overview:
- Reader-side counterpart to the bank write queue, which serialises parallel bank results into activation-buffer writes.
- This block turns one wide-fetch request into a burst of sequential reads on the activation buffer internal read port.
- It collects the returned words into a parallel vector and presents that vector to a consumer (feature loader / bank-parallel datapath) through a valid/ready handshake.

Parameters:
- numParallelOut, 4, number of buffer words gathered per request (output slots).
- readInterfaceWidth, 256, width of one buffer read word in bits.
- readAddrWidth, 32, buffer address width.
- addrStride, 32, address increment between consecutive reads (bytes per word, readInterfaceWidth/8).
- readLatency, 1, cycles from rd_en_o to valid rd_data_i (1..3 supported).

Ports:
- clk  input  1  clock.
- nrst  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous abort; highest priority.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  block can accept a request.
- req_addr_i  input  readAddrWidth  base address of first word.
- req_count_i  input  $clog2(numParallelOut+1)  words to read, 0..numParallelOut.
- rd_en_o  output  1  buffer read enable.
- rd_addr_o  output  readAddrWidth  buffer read address.
- rd_data_i  input  readInterfaceWidth  buffer read data.
- data_o  output  numParallelOut x readInterfaceWidth  gathered vector; slot i = word i.
- valid_o  output  1  data_o valid.
- ready_i  input  1  consumer accepts data_o.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (nrst low, async): state IDLE; req_ready_o=1; rd_en_o=0; rd_addr_o=0; data_o=0; valid_o=0; busy_o=0; in-flight tag pipeline cleared.
- All outputs are registered except req_ready_o, which is decoded from state (=1 only in IDLE).
- States:
  - IDLE: a request is accepted when req_valid_i && req_ready_o. On acceptance, latch base address and count (latch N), clear data_o to all-zero, reset the issue counter. If N=0, go to HOLD (no reads issued). Otherwise go to ISSUE.
  - ISSUE: one read per cycle. rd_en_o=1 and rd_addr_o=base+k*addrStride for k=0..N-1, on consecutive cycles with no gaps. Address arithmetic wraps modulo 2^readAddrWidth. After the k=N-1 issue, go to DRAIN.
  - DRAIN: no reads are issued. Returning data is captured until all N words have arrived, then go to HOLD.
  - HOLD: valid_o=1 and data_o is stable. When ready_i=1, clear valid_o and go to IDLE. A new request is accepted only from IDLE, one cycle later.
- Capture: each read carries a readLatency-deep shift tag {valid, slot index}. When a tag emerges, rd_data_i is written to data_o[slot]. Slots at or above N remain zero.
- Latency: with acceptance at edge T0, rd_en_o is high in cycles T0+1..T0+N and valid_o rises at T0+N+readLatency+1. For N=0, valid_o rises at T0+1.
- Stall: ready_i low holds data_o and valid_o indefinitely; no reads are issued during HOLD.
- ready_i high while valid_o=0 has no effect.
- clear_i=1 in any state:
  - next cycle: state IDLE, rd_en_o=0, valid_o=0, tag pipeline flushed;
  - data_o is not modified;
  - returns still in flight from before the clear are discarded;
  - a req_valid_i in the same cycle as clear_i is ignored.
- req_count_i > numParallelOut saturates to numParallelOut.
- Reset asserted mid-burst: outputs are at reset values immediately, with no further reads.

Test Plan:
- readLatency=1, req addr=0x100, count=4, ready_i=1 -> rd_en_o for 4 consecutive cycles at 0x100, 0x120, 0x140, 0x160; valid_o high one cycle at T0+6; data_o slots equal the returned words A0..A3 in order.
- count=2, addr=0x40 -> reads 0x40 and 0x60 only; slots 2 and 3 = 0; valid_o at T0+4.
- count=0 -> no rd_en_o; valid_o at T0+1 with data_o all-zero.
- addr=0xFFFFFFE0, count=3 -> rd_addr_o sequence 0xFFFFFFE0, 0x00000000, 0x00000020.
- Back-pressure: ready_i held low for 10 cycles after valid_o -> data_o stable, req_ready_o=0, no rd_en_o; one cycle after ready_i goes high, req_ready_o=1.
- readLatency=2, clear_i pulsed on the 3rd issue cycle of a count=4 burst -> next cycle IDLE, rd_en_o=0, valid_o never asserts. A follow-up request with count=1 returns only its own word in slot 0; stale in-flight data is not captured.

Source files
------------

// File: rtl/sipo_read_gather.sv
// +--------------------------------------------------------------------------+
// | sipo_read_gather: turns one wide-fetch request into a burst of buffer    |
// | reads and gathers the returned words into a parallel output vector.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sipo_read_gather #(
  parameter int NUM_PARALLEL_OUT     = 4,
  parameter int READ_INTERFACE_WIDTH = 256,
  parameter int READ_ADDR_WIDTH      = 32,
  parameter int ADDR_STRIDE          = 32,
  parameter int READ_LATENCY         = 1
) (
  input  logic                                              clk,
  input  logic                                              nrst,
  input  logic                                              clear_i,
  input  logic                                              req_valid_i,
  output logic                                              req_ready_o,
  input  logic [READ_ADDR_WIDTH-1:0]                        req_addr_i,
  input  logic [$clog2(NUM_PARALLEL_OUT+1)-1:0]             req_count_i,
  output logic                                              rd_en_o,
  output logic [READ_ADDR_WIDTH-1:0]                        rd_addr_o,
  input  logic [READ_INTERFACE_WIDTH-1:0]                   rd_data_i,
  output logic [NUM_PARALLEL_OUT-1:0][READ_INTERFACE_WIDTH-1:0] data_o,
  output logic                                              valid_o,
  input  logic                                              ready_i,
  output logic                                              busy_o
);

  localparam int CNT_W  = $clog2(NUM_PARALLEL_OUT + 1);
  localparam int SLOT_W = (NUM_PARALLEL_OUT > 1) ? $clog2(NUM_PARALLEL_OUT) : 1;
  localparam logic [CNT_W-1:0] C_MAX_COUNT = CNT_W'(NUM_PARALLEL_OUT);
  localparam logic [READ_ADDR_WIDTH-1:0] C_STRIDE = READ_ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_issue;

  // Stage 0 travels alongside rd_en_o; stage READ_LATENCY lines up with rd_data_i.
  logic              r_tag_v    [0:READ_LATENCY];
  logic [SLOT_W-1:0] r_tag_slot [0:READ_LATENCY];

  logic [CNT_W-1:0]  w_req_count;
  logic              w_cap;
  logic [SLOT_W-1:0] w_cap_slot;
  logic              w_last_cap;

  assign w_req_count = (req_count_i > C_MAX_COUNT) ? C_MAX_COUNT : req_count_i;
  assign w_cap       = r_tag_v[READ_LATENCY];
  assign w_cap_slot  = r_tag_slot[READ_LATENCY];
  assign w_last_cap  = w_cap && (CNT_W'(w_cap_slot) == (r_count - CNT_W'(1)));
  assign req_ready_o = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_issue   <= '0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        r_tag_v[i]    <= 1'b0;
        r_tag_slot[i] <= '0;
      end
    end else if (clear_i) begin
      r_state <= S_IDLE;
      rd_en_o <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        r_tag_v[i] <= 1'b0;
      end
    end else begin
      for (int i = READ_LATENCY; i > 0; i--) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_slot[i] <= r_tag_slot[i-1];
      end
      r_tag_v[0] <= 1'b0;
      rd_en_o    <= 1'b0;

      if (w_cap) begin
        data_o[w_cap_slot] <= rd_data_i;
      end

      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_count <= w_req_count;
            data_o  <= '0;
            busy_o  <= 1'b1;
            if (w_req_count == '0) begin
              r_issue <= '0;
              valid_o <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              // Word 0 is issued on the acceptance edge itself.
              rd_en_o       <= 1'b1;
              rd_addr_o     <= req_addr_i;
              r_tag_v[0]    <= 1'b1;
              r_tag_slot[0] <= '0;
              r_issue       <= CNT_W'(1);
              r_state       <= (w_req_count == CNT_W'(1)) ? S_DRAIN : S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          rd_en_o       <= 1'b1;
          rd_addr_o     <= rd_addr_o + C_STRIDE;
          r_tag_v[0]    <= 1'b1;
          r_tag_slot[0] <= SLOT_W'(r_issue);
          r_issue       <= r_issue + CNT_W'(1);
          if (r_issue == (r_count - CNT_W'(1))) begin
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // Returns arrive in issue order, so the last slot closes the burst.
          if (w_last_cap) begin
            valid_o <= 1'b1;
            r_state <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sipo_read_gather.sv
// +--------------------------------------------------------------------------+
// | tb_sipo_read_gather: two instances (read latency 1 and 2) driven in      |
// | lockstep and compared against a behavioural request/response model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sipo_read_gather;

  localparam int NPO    = 4;
  localparam int W      = 256;
  localparam int AW     = 32;
  localparam int STRIDE = 32;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic clear = 1'b0;
  logic req_valid = 1'b0;
  logic ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_count = '0;

  logic [1:0]                 req_ready, rd_en, valid, busy;
  logic [1:0][AW-1:0]         rd_addr;
  logic [1:0][W-1:0]          rd_data;
  logic [1:0][NPO-1:0][W-1:0] data;

  int checks = 0;
  int errors = 0;
  logic [31:0] salt = 32'h1234_5678;

  always #5 clk = ~clk;

  sipo_read_gather #(.READ_LATENCY(1)) u_lat1 (
    .clk(clk), .nrst(nrst), .clear_i(clear),
    .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr), .req_count_i(req_count),
    .rd_en_o(rd_en[0]), .rd_addr_o(rd_addr[0]), .rd_data_i(rd_data[0]),
    .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready), .busy_o(busy[0])
  );

  sipo_read_gather #(.READ_LATENCY(2)) u_lat2 (
    .clk(clk), .nrst(nrst), .clear_i(clear),
    .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr), .req_count_i(req_count),
    .rd_en_o(rd_en[1]), .rd_addr_o(rd_addr[1]), .rd_data_i(rd_data[1]),
    .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready), .busy_o(busy[1])
  );

  // Buffer contents are a function of address and a per-request salt.
  function automatic logic [W-1:0] word(input logic [AW-1:0] a);
    return {4{a ^ salt, a + salt}};
  endfunction

  function automatic logic [W-1:0] junk();
    return {8{$urandom}};
  endfunction

  logic [W-1:0] m1, m2a, m2b;
  always @(posedge clk) begin
    m1  <= rd_en[0] ? word(rd_addr[0]) : junk();
    m2a <= rd_en[1] ? word(rd_addr[1]) : junk();
    m2b <= m2a;
  end
  assign rd_data[0] = m1;
  assign rd_data[1] = m2b;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUTs idle; returns at a negedge, idle again.
  task automatic run_req(input logic [AW-1:0] addr, input logic [2:0] cnt, input int hold);
    int n, mv;
    int vo[2];
    int en_cnt[2];
    bit addr_ok[2], stable[2], rr_ok[2];
    logic [NPO-1:0][W-1:0] first[2];
    logic [AW-1:0] ea;
    n = (cnt > 3'(NPO)) ? NPO : int'(cnt);
    salt = $urandom;
    for (int d = 0; d < 2; d++) begin
      vo[d] = -1; en_cnt[d] = 0; addr_ok[d] = 1; stable[d] = 1; rr_ok[d] = 1;
      first[d] = '0;
    end
    req_addr = addr; req_count = cnt; req_valid = 1'b1; ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int off = 1; off <= 60; off++) begin
      for (int d = 0; d < 2; d++) begin
        if (rd_en[d] === 1'b1) begin
          en_cnt[d]++;
          ea = addr + AW'(en_cnt[d] - 1) * AW'(STRIDE);
          if (off != en_cnt[d] || rd_addr[d] !== ea) addr_ok[d] = 0;
        end
        if (valid[d] === 1'b1) begin
          if (vo[d] < 0) begin
            vo[d] = off;
            first[d] = data[d];
          end else if (data[d] !== first[d]) begin
            stable[d] = 0;
          end
        end
        if (req_ready[d] !== 1'b0) rr_ok[d] = 0;
      end
      mv = (vo[0] > vo[1]) ? vo[0] : vo[1];
      if (vo[0] >= 0 && vo[1] >= 0 && off >= mv + hold) break;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rd_count L%0d a=%0h n=%0d", d + 1, addr, n), W'(en_cnt[d]), W'(n));
      chk($sformatf("rd_seq L%0d a=%0h", d + 1, addr), W'(addr_ok[d]), W'(1));
      chk($sformatf("valid_time L%0d a=%0h", d + 1, addr), W'(vo[d]),
          W'((n == 0) ? 1 : n + (d + 1) + 1));
      for (int s = 0; s < NPO; s++)
        chk($sformatf("slot%0d L%0d a=%0h", s, d + 1, addr), first[d][s],
            (s < n) ? word(addr + AW'(s * STRIDE)) : '0);
      chk($sformatf("hold_stable L%0d", d + 1), W'(stable[d]), W'(1));
      chk($sformatf("req_ready_busy L%0d", d + 1), W'(rr_ok[d]), W'(1));
    end
    ready = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("valid_drop L%0d", d + 1), W'(valid[d]), W'(0));
      chk($sformatf("req_ready_back L%0d", d + 1), W'(req_ready[d]), W'(1));
    end
    ready = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ca;
    logic [W-1:0] w0;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_req_ready L%0d", d + 1), W'(req_ready[d]), W'(1));
      chk($sformatf("rst_rd_en L%0d", d + 1), W'(rd_en[d]), W'(0));
      chk($sformatf("rst_rd_addr L%0d", d + 1), W'(rd_addr[d]), W'(0));
      chk($sformatf("rst_valid L%0d", d + 1), W'(valid[d]), W'(0));
      chk($sformatf("rst_busy L%0d", d + 1), W'(busy[d]), W'(0));
      for (int s = 0; s < NPO; s++)
        chk($sformatf("rst_slot%0d L%0d", s, d + 1), data[d][s], '0);
    end
    nrst = 1'b1;
    @(negedge clk);

    run_req(32'h0000_0100, 3'd4, 0);
    run_req(32'h0000_0040, 3'd2, 0);
    run_req(32'h0000_0200, 3'd0, 0);
    run_req(32'hFFFF_FFE0, 3'd3, 0);
    run_req(32'h0000_1000, 3'd4, 10);
    run_req(32'h0000_0300, 3'd7, 1);

    // Abort on the third issue cycle of a four-word burst.
    salt = $urandom;
    ca = 32'h0000_0800;
    w0 = word(ca);
    req_addr = ca; req_count = 3'd4; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("clr_rd_en L%0d", d + 1), W'(rd_en[d]), W'(0));
      chk($sformatf("clr_valid L%0d", d + 1), W'(valid[d]), W'(0));
      chk($sformatf("clr_busy L%0d", d + 1), W'(busy[d]), W'(0));
      chk($sformatf("clr_req_ready L%0d", d + 1), W'(req_ready[d]), W'(1));
      // Only words whose return preceded the abort edge are kept.
      for (int s = 0; s < NPO; s++)
        chk($sformatf("clr_slot%0d L%0d", s, d + 1), data[d][s],
            (s < 2 - (d + 1)) ? w0 : '0);
    end
    run_req(32'h0000_0A00, 3'd1, 0);

    // A request coinciding with clear is dropped.
    req_addr = 32'h0000_0C00; req_count = 3'd2; req_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; clear = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("clr_req_busy L%0d", d + 1), W'(busy[d]), W'(0));
      chk($sformatf("clr_req_rd_en L%0d", d + 1), W'(rd_en[d]), W'(0));
    end
    @(negedge clk);

    // Reset in the middle of a burst.
    salt = $urandom;
    req_addr = 32'h0000_0E00; req_count = 3'd4; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mrst_rd_en L%0d", d + 1), W'(rd_en[d]), W'(0));
      chk($sformatf("mrst_rd_addr L%0d", d + 1), W'(rd_addr[d]), W'(0));
      chk($sformatf("mrst_valid L%0d", d + 1), W'(valid[d]), W'(0));
      chk($sformatf("mrst_busy L%0d", d + 1), W'(busy[d]), W'(0));
      chk($sformatf("mrst_req_ready L%0d", d + 1), W'(req_ready[d]), W'(1));
      chk($sformatf("mrst_data L%0d", d + 1), W'(data[d] != '0), W'(0));
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_req(AW'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
